// File: rtl/fifo_width_downsizer.sv
// Purpose: splits each wide FWFT FIFO word into RATIO narrow words, LSB slice first.
// Latency: a word popped in cycle t presents its first slice in t+1; one slice per cycle, no bubbles.
// Backpressure: out_full_n low freezes the held word and slice; upstream is popped only on the last beat.
module fifo_width_downsizer #(
   parameter int DATA_WIDTH = 32,
   parameter int RATIO      = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_empty_n,
   output logic                          in_read,
   output logic                          in_read_ce,
   input  logic [DATA_WIDTH*RATIO-1:0]   in_dout,
   input  logic                          out_full_n,
   output logic                          out_write,
   output logic                          out_write_ce,
   output logic [DATA_WIDTH-1:0]         out_din,
   output logic                          busy
);

   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

   // The two states are simply the value of valid_q.
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_HOLD = 1'b1;

   generate
      if (RATIO < 1) begin : g_bad_ratio
         $error("fifo_width_downsizer: RATIO must be >= 1");
      end
   endgenerate

   logic [DATA_WIDTH*RATIO-1:0] hold_q;
   logic                        valid_q;
   logic [IDX_W-1:0]            idx_q;
   logic                        beat;
   logic                        last;

   assign beat = (valid_q == ST_HOLD) & out_full_n;
   assign last = beat & (idx_q == IDX_LAST);

   // Refill when empty or on the final beat so consecutive wide words stream without a gap.
   // Gated by reset_n so nothing is popped (and lost) while the block is held in reset.
   assign in_read      = reset_n & in_empty_n & ((valid_q == ST_IDLE) | last);
   assign in_read_ce   = 1'b1;
   assign out_write    = valid_q;
   assign out_write_ce = 1'b1;
   assign busy         = valid_q;

   // Select the current slice of the held word.
   always_comb begin
      out_din = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (idx_q == IDX_W'(i)) begin
            out_din = hold_q[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Load a new word, retire the finished one, or advance to the next slice.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q  <= '0;
         valid_q <= ST_IDLE;
         idx_q   <= '0;
      end else if (in_read) begin
         hold_q  <= in_dout;
         valid_q <= ST_HOLD;
         idx_q   <= '0;
      end else if (last) begin
         valid_q <= ST_IDLE;
         idx_q   <= '0;
      end else if (beat) begin
         idx_q   <= idx_q + IDX_W'(1);
      end
   end

endmodule

// File: tb/tb_fifo_width_downsizer.sv
module tb_fifo_width_downsizer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   // RATIO=4, DATA_WIDTH=8 instance
   logic        in_empty_n4, in_read4, in_read_ce4, out_full_n4, out_write4, out_write_ce4, busy4;
   logic [31:0] in_dout4;
   logic [7:0]  out_din4;
   // RATIO=1, DATA_WIDTH=8 instance
   logic        in_empty_n1, in_read1, in_read_ce1, out_full_n1, out_write1, out_write_ce1, busy1;
   logic [7:0]  in_dout1;
   logic [7:0]  out_din1;

   fifo_width_downsizer #(.DATA_WIDTH(8), .RATIO(4)) dut4 (
      .clk(clk), .reset_n(reset_n),
      .in_empty_n(in_empty_n4), .in_read(in_read4), .in_read_ce(in_read_ce4), .in_dout(in_dout4),
      .out_full_n(out_full_n4), .out_write(out_write4), .out_write_ce(out_write_ce4),
      .out_din(out_din4), .busy(busy4)
   );

   fifo_width_downsizer #(.DATA_WIDTH(8), .RATIO(1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .in_empty_n(in_empty_n1), .in_read(in_read1), .in_read_ce(in_read_ce1), .in_dout(in_dout1),
      .out_full_n(out_full_n1), .out_write(out_write1), .out_write_ce(out_write_ce1),
      .out_din(out_din1), .busy(busy1)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Upstream FIFO contents, expected narrow stream, and event logs
   logic [31:0] up4[$];
   logic [7:0]  up1[$];
   logic [7:0]  exp4[$];
   logic [7:0]  exp1[$];
   int          rd_log4[$];
   int          wr_log4[$];
   logic [7:0]  dat_log4[$];

   logic gate4, full4, gate1, full1;
   logic pop4, pop1;
   logic stall4, stall1;
   logic [7:0] stall_dat4, stall_dat1;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic apply();
      in_empty_n4 = gate4 && (up4.size() != 0);
      in_dout4    = (up4.size() != 0) ? up4[0] : '0;
      out_full_n4 = full4;
      in_empty_n1 = gate1 && (up1.size() != 0);
      in_dout1    = (up1.size() != 0) ? up1[0] : '0;
      out_full_n1 = full1;
   endtask

   // Advance one cycle: retire the upstream word consumed at the edge, then drive new inputs.
   task automatic step();
      @(posedge clk);
      #1;
      if (pop4) begin void'(up4.pop_front()); pop4 = 1'b0; end
      if (pop1) begin void'(up1.pop_front()); pop1 = 1'b0; end
      apply();
      #1;
   endtask

   task automatic clear_logs();
      rd_log4.delete();
      wr_log4.delete();
      dat_log4.delete();
   endtask

   // Monitor: samples mid-cycle, predicts from upstream pops, checks every downstream push.
   always @(negedge clk) begin
      if (!reset_n) begin
         stall4 = 1'b0;
         stall1 = 1'b0;
      end else begin
         if (stall4) chk("stall_hold4", {out_write4, out_din4}, {1'b1, stall_dat4});
         if (stall1) chk("stall_hold1", {out_write1, out_din1}, {1'b1, stall_dat1});
         if (in_read4) begin
            chk("read_needs_data4", in_empty_n4, 1);
            if (in_empty_n4) begin
               for (int i = 0; i < 4; i++) exp4.push_back(in_dout4[i*8 +: 8]);
               pop4 = 1'b1;
               rd_log4.push_back(cyc);
            end
         end
         if (in_read1) begin
            chk("read_needs_data1", in_empty_n1, 1);
            if (in_empty_n1) begin
               exp1.push_back(in_dout1);
               pop1 = 1'b1;
            end
         end
         if (out_write4 && out_full_n4) begin
            wr_log4.push_back(cyc);
            dat_log4.push_back(out_din4);
            total++;
            if (exp4.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write4: got %0h expected no write", out_din4);
            end else if (out_din4 !== exp4[0]) begin
               bad++;
               $display("FAIL data4: got %0h expected %0h", out_din4, exp4[0]);
               void'(exp4.pop_front());
            end else begin
               void'(exp4.pop_front());
            end
         end
         if (out_write1 && out_full_n1) begin
            total++;
            if (exp1.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write1: got %0h expected no write", out_din1);
            end else if (out_din1 !== exp1[0]) begin
               bad++;
               $display("FAIL data1: got %0h expected %0h", out_din1, exp1[0]);
               void'(exp1.pop_front());
            end else begin
               void'(exp1.pop_front());
            end
         end
         stall4 = out_write4 && !out_full_n4;
         stall_dat4 = out_din4;
         stall1 = out_write1 && !out_full_n1;
         stall_dat1 = out_din1;
      end
   end

   initial begin
      logic [31:0] w;
      logic [7:0]  seq[6];

      reset_n = 1'b0;
      pop4 = 1'b0; pop1 = 1'b0; stall4 = 1'b0; stall1 = 1'b0;
      stall_dat4 = '0; stall_dat1 = '0;
      gate4 = 1'b1; full4 = 1'b1; gate1 = 1'b0; full1 = 1'b1;
      up4.push_back(32'hDDCCBBAA);
      apply();
      repeat (3) step();

      // Reset state, with upstream already offering a word
      chk("rst_out_write", out_write4, 0);
      chk("rst_in_read", in_read4, 0);
      chk("rst_out_din", out_din4, 0);
      chk("rst_busy", busy4, 0);
      chk("rst_ces", {in_read_ce4, out_write_ce4, in_read_ce1, out_write_ce1}, 4'hF);
      chk("rst_out_write1", {out_write1, busy1, in_read1}, 0);

      // Single word: AA BB CC DD on consecutive cycles starting one cycle after the pop
      clear_logs();
      reset_n = 1'b1;
      repeat (6) step();
      w = 32'hDDCCBBAA;
      chk("single_reads", rd_log4.size(), 1);
      chk("single_writes", wr_log4.size(), 4);
      if (rd_log4.size() == 1 && wr_log4.size() == 4) begin
         chk("single_latency", wr_log4[0] - rd_log4[0], 1);
         chk("single_contiguous", wr_log4[3] - wr_log4[0], 3);
         for (int i = 0; i < 4; i++) chk("single_order", dat_log4[i], w[i*8 +: 8]);
      end
      chk("single_idle_write", out_write4, 0);
      chk("single_idle_busy", busy4, 0);

      // Back-to-back: three words, sink always ready
      clear_logs();
      for (int i = 0; i < 3; i++) up4.push_back($urandom);
      repeat (16) step();
      chk("b2b_reads", rd_log4.size(), 3);
      chk("b2b_writes", wr_log4.size(), 12);
      if (rd_log4.size() == 3 && wr_log4.size() == 12) begin
         chk("b2b_pop1", rd_log4[1] - rd_log4[0], 4);
         chk("b2b_pop2", rd_log4[2] - rd_log4[0], 8);
         chk("b2b_no_gap", wr_log4[11] - wr_log4[0], 11);
         chk("b2b_latency", wr_log4[0] - rd_log4[0], 1);
      end

      // Backpressure after beat 1 for 5 cycles
      clear_logs();
      up4.push_back(32'hDDCCBBAA);
      up4.push_back(32'h88776655);
      step();
      step();
      full4 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_write", out_write4, 1);
         chk("bp_hold_data", out_din4, 8'hBB);
         chk("bp_no_pop", in_read4, 0);
      end
      full4 = 1'b1;
      repeat (10) step();
      chk("bp_reads", rd_log4.size(), 2);
      if (rd_log4.size() == 2) chk("bp_pop_gap", rd_log4[1] - rd_log4[0], 9);
      if (dat_log4.size() >= 4) begin
         w = 32'hDDCCBBAA;
         for (int i = 0; i < 4; i++) chk("bp_order", dat_log4[i], w[i*8 +: 8]);
      end

      // Starvation: upstream dries up after the pop, returns 3 cycles after the last beat
      clear_logs();
      up4.push_back(32'hA4A3A2A1);
      step();
      gate4 = 1'b0;
      up4.push_back(32'hB4B3B2B1);
      repeat (5) step();
      chk("starve_idle_write", out_write4, 0);
      chk("starve_idle_busy", busy4, 0);
      step();
      gate4 = 1'b1;
      repeat (7) step();
      chk("starve_reads", rd_log4.size(), 2);
      chk("starve_writes", wr_log4.size(), 8);
      if (rd_log4.size() == 2 && wr_log4.size() == 8) begin
         chk("starve_gap", rd_log4[1] - rd_log4[0], 7);
         chk("starve_restart_lat", wr_log4[4] - rd_log4[1], 1);
         chk("starve_restart_slice0", dat_log4[4], 8'hB1);
      end

      // Asynchronous reset after beat 2: old word's CC/DD are dropped
      clear_logs();
      up4.push_back(32'hDDCCBBAA);
      up4.push_back(32'h44332211);
      repeat (4) step();
      #2 reset_n = 1'b0;
      #1;
      chk("arst_write", out_write4, 0);
      chk("arst_busy", busy4, 0);
      chk("arst_read", in_read4, 0);
      exp4.delete();
      exp1.delete();
      step();
      step();
      reset_n = 1'b1;
      repeat (6) step();
      seq[0] = 8'hAA; seq[1] = 8'hBB; seq[2] = 8'h11;
      seq[3] = 8'h22; seq[4] = 8'h33; seq[5] = 8'h44;
      chk("arst_writes", dat_log4.size(), 6);
      if (dat_log4.size() == 6) begin
         for (int i = 0; i < 6; i++) chk("arst_stream", dat_log4[i], seq[i]);
      end

      // Random traffic on both instances, RATIO=1 for 10k cycles
      for (int n = 0; n < 10000; n++) begin
         if (up4.size() < 3) up4.push_back($urandom);
         if (up1.size() < 3) up1.push_back(8'($urandom));
         gate4 = ($urandom_range(0, 3) != 0);
         full4 = ($urandom_range(0, 2) != 0);
         gate1 = ($urandom_range(0, 3) != 0);
         full1 = ($urandom_range(0, 2) != 0);
         step();
      end
      gate4 = 1'b1; full4 = 1'b1; gate1 = 1'b1; full1 = 1'b1;
      repeat (30) step();
      chk("drain_up4", up4.size(), 0);
      chk("drain_exp4", exp4.size(), 0);
      chk("drain_up1", up1.size(), 0);
      chk("drain_exp1", exp1.size(), 0);
      chk("drain_idle", {out_write4, busy4, out_write1, busy1}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_width_downsizer.md
# fifo_width_downsizer

Stream width converter sitting between two TAPA FWFT FIFOs. It acts as the initiator on both sides: it drains wide words from an upstream FIFO read port and writes them as RATIO narrow words into a downstream FIFO write port, LSB slice first. It sustains one narrow word per cycle with no bubble between consecutive wide words. It is inserted where a wide producer feeds a narrow consumer.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one narrow output word.
- RATIO, 4, narrow words per wide word; must be ≥ 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_empty_n  in  1  upstream FIFO holds a word.
- in_read  out  1  pop the upstream FIFO this cycle.
- in_read_ce  out  1  constant 1'b1.
- in_dout  in  DATA_WIDTH*RATIO  upstream FWFT head word.
- out_full_n  in  1  downstream FIFO can accept a word.
- out_write  out  1  push to the downstream FIFO this cycle.
- out_write_ce  out  1  constant 1'b1.
- out_din  out  DATA_WIDTH  narrow word being pushed.
- busy  out  1  a wide word is held, and not all of its slices have been written.

## Operation
- State: hold_q (DATA_WIDTH*RATIO), valid_q (1), idx_q (clog2(RATIO) bits, 1 bit when RATIO=1).
- Two states, derived from valid_q:
  - IDLE (valid_q=0): no word held.
  - HOLD (valid_q=1): holding a word; idx_q selects the next slice.
- out_write = valid_q.
- out_din = hold_q[idx_q*DATA_WIDTH +: DATA_WIDTH].
- busy = valid_q.
- beat = valid_q & out_full_n.
- last = beat & (idx_q == RATIO-1).
- in_read = in_empty_n & (~valid_q | last). This is combinational from out_full_n; there is no registered path.
- When in_read = 1: hold_q ← in_dout, valid_q ← 1, idx_q ← 0.
- Else, on last: valid_q ← 0, idx_q ← 0.
- Else, on beat: idx_q ← idx_q + 1. idx_q never exceeds RATIO-1 and never wraps through unused codes.
- Slice order: bits [DATA_WIDTH-1:0] are written first, and the MSB slice is written last.
- out_full_n = 0 in HOLD: hold_q, idx_q and out_din stay stable, out_write stays 1, and in_read = 0.
- in_empty_n = 0 at the last beat: return to IDLE; in_read = 0.
- RATIO = 1: every beat is a last beat; the block acts as a one-deep pipeline register with full throughput.
- Reset mid-operation: the held word and any unsent slices are discarded. No partial word is replayed after reset.

## Timing
- Reset values: out_write=0, in_read=0 (because valid_q=0 and in_empty_n is ignored while reset_n=0), out_din=0, busy=0, in_read_ce=1, out_write_ce=1.
- Latency: with in_empty_n high at cycle t in IDLE, in_read=1 at t, and the first narrow word is presented (out_write=1) at t+1.
- Throughput: with out_full_n and in_empty_n held at 1, out_write stays 1 every cycle indefinitely. Upstream pops occur once every RATIO cycles, on the cycle of each last beat.
- Handshake: a narrow word transfers exactly on a cycle where out_write & out_full_n. An upstream word is consumed exactly on a cycle where in_read & in_empty_n. in_read is never asserted when in_empty_n=0.
- Reset release: the block is first active on the first rising edge after reset_n deasserts; reset_n deassertion is synchronised by the caller.

## Structure
- No shared package. The index width is localparam IDX_W = (RATIO>1) ? $clog2(RATIO) : 1.
- Single flat module, no sub-modules; under 200 lines.
- Elaboration-time check: RATIO < 1 triggers $error.

## Test plan
- Single word, DATA_WIDTH=8, RATIO=4, in_dout=32'hDDCCBBAA, out_full_n=1 → out_din sequence AA, BB, CC, DD on four consecutive cycles starting one cycle after in_read; then out_write=0 and busy=0.
- Back-to-back, upstream holds 3 words, sink always ready → 12 consecutive out_write cycles with no gap; in_read pulses on cycles 0, 4, 8 relative to the first pop.
- Backpressure: drop out_full_n to 0 after beat 1 for 5 cycles → out_din holds BB and out_write stays 1 throughout; no upstream pop; the sequence resumes BB, CC, DD.
- Starvation: in_empty_n drops right after the first pop, then returns 3 cycles after the last beat → block goes to IDLE, then restarts at slice 0 of the new word.
- Async reset after beat 2 (reset_n low mid-cycle for 2 cycles) → out_write and busy go to 0 immediately; after release the next word's slice 0 is emitted, and slices CC/DD of the old word never appear.
- RATIO=1, random in_empty_n/out_full_n for 10k cycles → a scoreboard sees the output stream equal to the input stream, and no write occurs while out_full_n=0 without holding.
